abus_slave_regfile: RTL and testbench

//  abus responder (slave end) for the abus master. Decodes read/write requests

---
 rtl/abus_slave_regfile_if.sv | 16 +
 rtl/abus_slave_regfile.sv | 113 +++++++++++
 tb/tb_abus_slave_regfile.sv | 138 +++++++++++++
 3 files changed

// File: rtl/abus_slave_regfile_if.sv
// abus_slave_regfile_if: abus request/response signal bundle between master and slave
interface abus_slave_regfile_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  write;
  logic                  read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  done;
  logic                  new_rdata;
  logic                  err;
  modport master (output write, read, address, wdata, input rdata, done, new_rdata, err);
  modport slave  (input write, read, address, wdata, output rdata, done, new_rdata, err);
endinterface

// File: rtl/abus_slave_regfile.sv
// abus_slave_regfile: abus slave with NREGS R/W registers, a read-only status word and
// wait-state insertion; define ABUS_SLAVE_LOCK_EN to add the sticky write-lock register.
module abus_slave_regfile #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int BASE_ADDR   = 0,
  parameter int NREGS       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                        abus_clk,
  input  logic                        abus_rst,
  abus_slave_regfile_if.slave         bus,
  input  logic [DATA_WIDTH-1:0]       sts_in,
  output logic [NREGS*DATA_WIDTH-1:0] reg_q
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, TURN = 2'd3;
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] BA = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] NR = ADDR_WIDTH'(NREGS);
  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d, off;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d, rdata_q, rdata_d, rd_val;
  logic                        done_q, done_d, new_rdata_q, new_rdata_d, err_q, err_d;
  logic [NREGS*DATA_WIDTH-1:0] reg_d;
  logic                        below, in_reg, is_sts, is_lock, lock_q, bad, fire;
  assign off    = addr_q - BA;
  assign below  = addr_q < BA;
  assign in_reg = !below && off < NR;
  assign is_sts = !below && off == NR;
  assign fire   = state_q == WAIT && cnt_q == '0;
  assign bad    = (rd_q & wr_q) | !(in_reg | is_sts | is_lock) | (wr_q & (is_sts | (in_reg & lock_q)));
`ifdef ABUS_SLAVE_LOCK_EN
  logic lock_d;
  assign is_lock = !below && off == ADDR_WIDTH'(NREGS + 1);
  assign lock_d  = lock_q | (fire && !bad && wr_q && is_lock && wdata_q[0]);
  always_ff @(posedge abus_clk) lock_q <= abus_rst ? 1'b0 : lock_d;
`else
  assign is_lock = 1'b0;
  assign lock_q  = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    reg_d       = reg_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    new_rdata_d = 1'b0;
    err_d       = 1'b0;
    rd_val      = is_sts ? sts_in : is_lock ? DATA_WIDTH'(lock_q) : '0;
    for (int i = 0; i < NREGS; i++)
      if (off == ADDR_WIDTH'(i)) rd_val = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    if (state_q == IDLE && (bus.read || bus.write)) begin
      rd_d    = bus.read;
      wr_d    = bus.write;
      addr_d  = bus.address;
      wdata_d = bus.wdata;
      cnt_d   = CW'(WAIT_STATES);
      state_d = WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
      if (fire) begin
        state_d     = RESP;
        err_d       = bad;
        done_d      = !bad && wr_q;
        new_rdata_d = !bad && rd_q;
        rdata_d     = (!bad && rd_q) ? rd_val : rdata_q;
        for (int i = 0; i < NREGS; i++)
          if (!bad && wr_q && off == ADDR_WIDTH'(i)) reg_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      end
    end else if (state_q == RESP) begin
      state_d = TURN;
    end else if (state_q == TURN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      reg_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      new_rdata_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      reg_q       <= reg_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      new_rdata_q <= new_rdata_d;
      err_q       <= err_d;
    end
  end
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.new_rdata = new_rdata_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_abus_slave_regfile.sv
// tb_abus_slave_regfile: scoreboard bench for abus_slave_regfile (BASE 0x0100, 8 regs, 1 wait state)
module tb_abus_slave_regfile;
  localparam int AW = 16, DW = 16, NREGS = 8, WS = 1;
  localparam logic [AW-1:0] BASE = 16'h0100;
  localparam logic [2:0] K_DONE = 3'b001, K_RD = 3'b010, K_ERR = 3'b100;
  typedef struct packed {
    logic [2:0]    kind;
    logic [DW-1:0] data;
  } exp_t;
  logic                  abus_clk = 1'b0;
  logic                  abus_rst = 1'b1;
  logic [DW-1:0]         sts_in   = '0;
  logic [NREGS*DW-1:0]   reg_q;
  exp_t                  sbq[$];
  exp_t                  mon_e;
  logic [DW-1:0]         mdl[NREGS];
  logic [DW-1:0]         last_rd = '0;
  int                    checks = 0, errors = 0;
  abus_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  abus_slave_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(256), .NREGS(NREGS), .WAIT_STATES(WS)
  ) dut (
    .abus_clk(abus_clk), .abus_rst(abus_rst), .bus(bus), .sts_in(sts_in), .reg_q(reg_q)
  );
  always #5 abus_clk = ~abus_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge abus_clk) begin
    if (!abus_rst && (bus.done || bus.new_rdata || bus.err)) begin
      if (sbq.size() == 0) chk("unexpected_pulse", {29'b0, bus.err, bus.new_rdata, bus.done}, 32'd0);
      else begin
        mon_e = sbq.pop_front();
        chk("resp_kind", {29'b0, bus.err, bus.new_rdata, bus.done}, {29'b0, mon_e.kind});
        chk("rdata", {16'b0, bus.rdata}, {16'b0, mon_e.data});
      end
    end
  end
  task automatic chk_regs();
    for (int i = 0; i < NREGS; i++) chk("reg_q", {16'b0, reg_q[i*DW +: DW]}, {16'b0, mdl[i]});
  endtask
  task automatic req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [2:0] ek, input logic [DW-1:0] ed);
    exp_t e;
    int   lat;
    logic seen;
    if (ek == K_RD) last_rd = ed;
    e.kind = ek;
    e.data = last_rd;
    sbq.push_back(e);
    for (int i = 0; i < NREGS; i++) if (ek == K_DONE && addr == BASE + 16'(i)) mdl[i] = wd;
    bus.read = rd;
    bus.write = wr;
    bus.address = addr;
    bus.wdata = wd;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge abus_clk);
      lat++;
      seen = bus.done | bus.new_rdata | bus.err;
    end
    chk("latency", lat, WS + 2);
    chk_regs();
    bus.read = 1'b0;
    bus.write = 1'b0;
    @(negedge abus_clk);
    chk("pulse_width", {29'b0, bus.err, bus.new_rdata, bus.done}, 32'd0);
    @(negedge abus_clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.wdata = '0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    repeat (3) @(negedge abus_clk);
    abus_rst = 1'b0;
    chk("rst_rdata", {16'b0, bus.rdata}, 32'd0);
    chk("rst_pulses", {29'b0, bus.err, bus.new_rdata, bus.done}, 32'd0);
    chk_regs();
    for (int i = 0; i < NREGS; i++) req(1, 0, BASE + 16'(i), 16'h0, K_RD, 16'h0);
    req(0, 1, BASE + 16'd3, 16'hBEEF, K_DONE, 16'h0);
    req(1, 0, BASE + 16'd3, 16'h0, K_RD, 16'hBEEF);
    req(0, 1, BASE + 16'd0, 16'hA5A5, K_DONE, 16'h0);
    req(0, 1, BASE + 16'd7, 16'h1357, K_DONE, 16'h0);
    req(1, 0, BASE + 16'd7, 16'h0, K_RD, 16'h1357);
    req(1, 0, BASE + 16'd0, 16'h0, K_RD, 16'hA5A5);
    sts_in = 16'h1234;
    req(1, 0, BASE + 16'd8, 16'h0, K_RD, 16'h1234);
    req(0, 1, BASE + 16'd8, 16'hFFFF, K_ERR, 16'h0);
    req(1, 0, BASE + 16'd13, 16'h0, K_ERR, 16'h0);
    req(0, 1, BASE + 16'd13, 16'h4444, K_ERR, 16'h0);
    req(1, 1, BASE + 16'd1, 16'h6666, K_ERR, 16'h0);
    req(1, 0, 16'h00FF, 16'h0, K_ERR, 16'h0);
    req(0, 1, 16'h00FF, 16'h7777, K_ERR, 16'h0);
    bus.write = 1'b1;
    bus.address = BASE + 16'd5;
    bus.wdata = 16'h5555;
    @(negedge abus_clk);
    abus_rst = 1'b1;
    bus.write = 1'b0;
    @(negedge abus_clk);
    abus_rst = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    last_rd = '0;
    repeat (4) @(negedge abus_clk);
    chk("abort_reg5", {16'b0, reg_q[5*DW +: DW]}, 32'd0);
    chk_regs();
    req(0, 1, BASE + 16'd5, 16'h1111, K_DONE, 16'h0);
    req(1, 0, BASE + 16'd5, 16'h0, K_RD, 16'h1111);
`ifdef ABUS_SLAVE_LOCK_EN
    req(1, 0, BASE + 16'd9, 16'h0, K_RD, 16'h0000);
    req(0, 1, BASE + 16'd9, 16'h0000, K_DONE, 16'h0);
    req(0, 1, BASE + 16'd0, 16'h2222, K_DONE, 16'h0);
    req(0, 1, BASE + 16'd9, 16'h0001, K_DONE, 16'h0);
    req(0, 1, BASE + 16'd0, 16'h3333, K_ERR, 16'h0);
    req(1, 0, BASE + 16'd9, 16'h0, K_RD, 16'h0001);
    req(1, 0, BASE + 16'd0, 16'h0, K_RD, 16'h2222);
`else
    req(1, 0, BASE + 16'd9, 16'h0, K_ERR, 16'h0);
    req(0, 1, BASE + 16'd9, 16'h0001, K_ERR, 16'h0);
    req(0, 1, BASE + 16'd0, 16'h3333, K_DONE, 16'h0);
`endif
    chk("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
